// File: rtl/ram_fifo_pkg.sv
// Shared constants for the RAM-backed FIFO controller and its skid buffer.
// Also holds the helper that counts read credits in use.
package ram_fifo_pkg;

    localparam int RAM_RD_LATENCY = 2;
    localparam int SKID_DEPTH     = 4;
    localparam int SKID_IDX_W     = $clog2(SKID_DEPTH);
    localparam int SKID_CNT_W     = SKID_IDX_W + 1;
    localparam int CREDIT_W       = SKID_CNT_W + 1;

    // Words in flight plus words held: each one owns a skid slot.
    function automatic logic [CREDIT_W-1:0] credits_used(
        input logic [RAM_RD_LATENCY-1:0] iss,
        input logic [SKID_CNT_W-1:0]     cnt
    );
        logic [CREDIT_W-1:0] n;
        n = CREDIT_W'(cnt);
        for (int i = 0; i < RAM_RD_LATENCY; i++) begin
            n = n + CREDIT_W'(iss[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/ram_fifo_skid.sv
// 4-entry register FIFO that catches words returning from the RAM.
// Ports: clk_i, rst_i, flush_i, wr_en_i/wr_data_i, rd_en_i, head_o, count_o.
module ram_fifo_skid
    import ram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 36
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic [SKID_CNT_W-1:0] count_o
);

    logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
    logic [SKID_IDX_W-1:0] wr_idx_q;
    logic [SKID_IDX_W-1:0] rd_idx_q;
    logic [SKID_CNT_W-1:0] cnt_q;
    logic [SKID_CNT_W-1:0] cnt_d;

    assign cnt_d = cnt_q + SKID_CNT_W'(wr_en_i)
                         - SKID_CNT_W'(rd_en_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_idx_q] <= wr_data_i;
                wr_idx_q        <= wr_idx_q + 1'b1;
            end
            if (rd_en_i) begin
                rd_idx_q <= rd_idx_q + 1'b1;
            end
            cnt_q <= cnt_d;
        end
    end

    assign head_o  = mem_q[rd_idx_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FWFT FIFO controller over a 2-cycle-latency dual-port RAM.
// Ports: write side in_*, read side out_*, RAM port A/B ram_*, status counts.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [ADDR_WIDTH+1:0] fill_count,
    output logic                  empty,
    output logic                  full
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam int FW = ADDR_WIDTH + 2;

    // Pointers carry an extra MSB so full and empty differ.
    logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]             ram_occ;
    logic [RAM_RD_LATENCY-1:0] iss_q, iss_d;
    logic [FW-1:0]             fill_q, fill_d;
    logic [SKID_CNT_W-1:0]     skid_cnt;
    logic [DATA_WIDTH-1:0]     skid_head;
    logic                      ram_full;
    logic                      push, pop, issue, land;

    assign ram_occ  = wr_ptr_q - rd_ptr_q;
    assign ram_full = ram_occ[ADDR_WIDTH];

    assign in_ready = ~ram_full & ~flush & ~Reset;
    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready & ~flush;

    // Only issue when a skid slot is reserved for the returning word.
    assign issue = ~flush & (ram_occ != '0)
                 & (credits_used(iss_q, skid_cnt)
                    < CREDIT_W'(SKID_DEPTH));
    assign land  = iss_q[RAM_RD_LATENCY-1] & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(issue);
        iss_d    = {iss_q[RAM_RD_LATENCY-2:0], issue};
        fill_d   = fill_q + FW'(push) - FW'(pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            iss_d    = '0;
            fill_d   = '0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            iss_q    <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            iss_q    <= iss_d;
            fill_q   <= fill_d;
        end
    end

    ram_fifo_skid #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk_i    (Clk),
        .rst_i    (Reset),
        .flush_i  (flush),
        .wr_en_i  (land),
        .wr_data_i(ram_rd_data),
        .rd_en_i  (pop),
        .head_o   (skid_head),
        .count_o  (skid_cnt)
    );

    assign ram_wr_en   = push;
    assign ram_wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
    assign ram_wr_data = in_data;
    assign ram_rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

    assign out_valid  = (skid_cnt != '0);
    assign out_data   = skid_head;
    assign fill_count = fill_q;
    assign empty      = (fill_q == '0);
    assign full       = ram_full;

endmodule
